// File: rtl/cache_controller_assoc_pkg.sv
// Shared types and helpers for the set-associative cache controller.
package cache_controller_assoc_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } fill_state_e;

   // Width of an age counter / way index; a direct-mapped cache still needs one bit.
   function automatic int age_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/cache_controller_assoc_if.sv
// CPU-side request bus and memory-side fill/write bus of the cache controller.
interface cache_controller_assoc_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   // Handshake: a request is taken when cache_enable=1 and cache_miss=0; the CPU
   // holds its request while cache_miss=1. Memory always accepts mem_read/mem_write
   // and answers reads in issue order with memory_data_valid.
   logic              cache_enable;
   logic              write;
   logic [ADDR_W-1:0] cache_address;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              cache_miss;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] memory_address;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] memory_data;
   logic              memory_data_valid;

   modport slave (
      input  cache_enable, write, cache_address, data_in, memory_data, memory_data_valid,
      output data_out, cache_miss, mem_read, mem_write, memory_address, mem_write_data
   );

   modport master (
      output cache_enable, write, cache_address, data_in, memory_data, memory_data_valid,
      input  data_out, cache_miss, mem_read, mem_write, memory_address, mem_write_data
   );
endinterface

// File: rtl/cache_controller_assoc_fill_fsm.sv
// Block fill sequencer: issues WORDS pipelined reads and counts the in-order returns.
module cache_controller_assoc_fill_fsm
   import cache_controller_assoc_pkg::*;
#(
   parameter int WORDS  = 8,
   parameter int ADDR_W = 16,
   localparam int OFF_W = $clog2(WORDS),
   localparam int BLK_W = ADDR_W - 1 - OFF_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [BLK_W-1:0]  blk_i,
   input  logic              mem_valid_i,
   output fill_state_e       state_o,
   output logic              mem_read_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [BLK_W-1:0]  blk_o,
   output logic              data_we_o,
   output logic [OFF_W-1:0]  word_off_o,
   output logic              tag_we_o
);
   localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS - 1);

   fill_state_e      state_q;
   logic             issue_q;
   logic [OFF_W-1:0] icnt_q;
   logic [OFF_W-1:0] rcnt_q;
   logic [BLK_W-1:0] blk_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         issue_q <= 1'b0;
         icnt_q  <= '0;
         rcnt_q  <= '0;
         blk_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_q <= ST_FILL;
                  issue_q <= 1'b1;
                  icnt_q  <= '0;
                  rcnt_q  <= '0;
                  blk_q   <= blk_i;
               end
            end
            ST_FILL: begin
               // Counters wrap inside the block; the block number never carries.
               if (issue_q) begin
                  icnt_q <= icnt_q + OFF_W'(1);
                  if (icnt_q == LAST) issue_q <= 1'b0;
               end
               if (mem_valid_i) begin
                  rcnt_q <= rcnt_q + OFF_W'(1);
                  if (rcnt_q == LAST) state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign state_o    = state_q;
   assign mem_read_o = issue_q;
   assign mem_addr_o = {blk_q, icnt_q, 1'b0};
   assign blk_o      = blk_q;
   assign data_we_o  = (state_q == ST_FILL) && mem_valid_i;
   assign word_off_o = rcnt_q;
   assign tag_we_o   = data_we_o && (rcnt_q == LAST);

endmodule

// File: rtl/cache_controller_assoc.sv
// N-way set-associative, write-through / no-write-allocate cache with true-LRU replacement.
module cache_controller_assoc
   import cache_controller_assoc_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int WORDS  = 8,
   parameter int SETS   = 8,
   parameter int WAYS   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   cache_controller_assoc_if.slave bus,
   output fill_state_e             dbg_state_o
);
   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int BLK_W = ADDR_W - 1 - OFF_W;
   localparam int TAG_W = BLK_W - IDX_W;
   localparam int AGE_W = age_bits(WAYS);

   logic [DATA_W-1:0] data_q  [WAYS][SETS][WORDS];
   logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
   logic              valid_q [WAYS][SETS];
   logic [AGE_W-1:0]  age_q   [WAYS][SETS];
   logic [AGE_W-1:0]  victim_q, victim_d, hit_way, lru_way;
   logic [IDX_W-1:0]  idx, fill_idx, lru_set;
   logic [TAG_W-1:0]  tag, fill_tag;
   logic [OFF_W-1:0]  off, fill_off;
   logic [BLK_W-1:0]  fill_blk;
   logic [ADDR_W-1:0] fill_addr, mem_addr;
   logic              hit, idle, rd_hit, rd_miss, wr_req, wr_hit, lru_en;
   logic              fill_rd, fill_data_we, fill_tag_we;
   fill_state_e       fill_state;

   assign off      = bus.cache_address[1 +: OFF_W];
   assign idx      = bus.cache_address[OFF_W+1 +: IDX_W];
   assign tag      = bus.cache_address[ADDR_W-1 -: TAG_W];
   assign fill_idx = fill_blk[IDX_W-1:0];
   assign fill_tag = fill_blk[BLK_W-1 -: TAG_W];

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
            hit     = 1'b1;
            hit_way = AGE_W'(w);
         end
      end
   end

   // Lowest-index invalid way wins over the oldest valid way.
   always_comb begin
      victim_d = '0;
      for (int w = WAYS - 1; w >= 0; w--)
         if (age_q[w][idx] == AGE_W'(WAYS - 1)) victim_d = AGE_W'(w);
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid_q[w][idx]) victim_d = AGE_W'(w);
   end

   // Requests are only decoded in IDLE and are squashed while reset is asserted.
   assign idle    = (fill_state == ST_IDLE);
   assign wr_req  = rst_n && idle && bus.cache_enable && bus.write;
   assign wr_hit  = wr_req && hit;
   assign rd_hit  = rst_n && idle && bus.cache_enable && !bus.write && hit;
   assign rd_miss = rst_n && idle && bus.cache_enable && !bus.write && !hit;

   cache_controller_assoc_fill_fsm #(.WORDS(WORDS), .ADDR_W(ADDR_W)) u_fill (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (rd_miss),
      .blk_i       (bus.cache_address[ADDR_W-1:OFF_W+1]),
      .mem_valid_i (bus.memory_data_valid),
      .state_o     (fill_state),
      .mem_read_o  (fill_rd),
      .mem_addr_o  (fill_addr),
      .blk_o       (fill_blk),
      .data_we_o   (fill_data_we),
      .word_off_o  (fill_off),
      .tag_we_o    (fill_tag_we)
   );

   assign lru_en  = fill_tag_we || rd_hit || wr_hit;
   assign lru_set = fill_tag_we ? fill_idx : idx;
   assign lru_way = fill_tag_we ? victim_q : hit_way;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         victim_q <= '0;
         for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               valid_q[w][s] <= 1'b0;
               age_q[w][s]   <= AGE_W'(w);
            end
         end
      end else begin
         if (rd_miss) victim_q <= victim_d;
         if (fill_tag_we) valid_q[victim_q][fill_idx] <= 1'b1;
         // Touched way becomes youngest; only ways younger than it grow older.
         if (lru_en) begin
            for (int w = 0; w < WAYS; w++) begin
               if (AGE_W'(w) == lru_way)
                  age_q[w][lru_set] <= '0;
               else if (age_q[w][lru_set] < age_q[lru_way][lru_set])
                  age_q[w][lru_set] <= age_q[w][lru_set] + AGE_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fill_data_we) data_q[victim_q][fill_idx][fill_off] <= bus.memory_data;
      if (fill_tag_we)  tag_q[victim_q][fill_idx] <= fill_tag;
      if (wr_hit)       data_q[hit_way][idx][off] <= bus.data_in;
   end

   always_comb begin
      mem_addr = '0;
      if (fill_rd)     mem_addr = fill_addr;
      else if (wr_req) mem_addr = bus.cache_address & ~ADDR_W'(1);
   end

   assign bus.data_out       = rd_hit ? data_q[hit_way][idx][off] : '0;
   assign bus.cache_miss     = rd_miss || (fill_state == ST_FILL);
   assign bus.mem_read       = fill_rd;
   assign bus.mem_write      = wr_req;
   assign bus.memory_address = mem_addr;
   assign bus.mem_write_data = wr_req ? bus.data_in : '0;
   assign dbg_state_o        = fill_state;

endmodule
